// File: rtl/seq_generator_pkg.sv
// Shared types and defaults for the serial pattern generator and the detector benches.
// State encodings are fixed because detector benches decode them directly.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_e;

    localparam int unsigned SEQ_MAX_LEN = 16;
    localparam int unsigned SEQ_LEN_W   = 5;
    localparam int unsigned SEQ_REP_W   = 4;
    localparam int unsigned SEQ_GAP     = 2;

    function automatic logic len_valid(input logic [31:0] len, input int unsigned max_len);
        return (len != 32'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_generator_if.sv
// Load handshake and serial output bundle of seq_generator.
// master drives the load side; slave is the generator itself.
interface seq_generator_if #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned REP_W   = 4
);
    logic [MAX_LEN-1:0] pat_in;
    logic [LEN_W-1:0]   len_in;
    logic [REP_W-1:0]   rep_in;
    logic               load_valid;
    logic               load_ready;
    logic               abort;
    logic               seq_out;
    logic               seq_valid;
    logic               frame_start;
    logic               done;
    logic               err;
    logic               busy;

    modport master (
        output pat_in, len_in, rep_in, load_valid, abort,
        input  load_ready, seq_out, seq_valid, frame_start, done, err, busy
    );

    modport slave (
        input  pat_in, len_in, rep_in, load_valid, abort,
        output load_ready, seq_out, seq_valid, frame_start, done, err, busy
    );
endinterface

// File: rtl/seq_generator_piso.sv
// Loadable parallel-in/serial-out pattern register with a wrapping index down-counter.
// Stepping on the last bit reloads index len-1, so repeats need no separate reload.
module seq_piso
    import seq_pkg::*;
#(
    parameter int unsigned MAX_LEN = SEQ_MAX_LEN,
    parameter int unsigned LEN_W   = SEQ_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [MAX_LEN-1:0] pat_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               bit_o,
    output logic               first_o,
    output logic               last_o
);
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [MAX_LEN-1:0] shifted;

    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        idx_d = idx_q;
        if (load_i) begin
            pat_d = pat_i;
            len_d = len_i;
            idx_d = len_i - LEN_W'(1);
        end else if (step_i) begin
            if (idx_q == '0) begin
                idx_d = len_q - LEN_W'(1);
            end else begin
                idx_d = idx_q - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        shifted = pat_q >> idx_q;
        bit_o   = shifted[0];
        first_o = (idx_q == (len_q - LEN_W'(1)));
        last_o  = (idx_q == '0);
    end
endmodule

// File: rtl/seq_generator.sv
// Serial pattern transmitter: shifts a loaded pattern out MSB-first, rep+1 times, GAP idle cycles apart.
// The FSM runs one cycle ahead of the registered outputs, so outputs lag the state by one cycle.
module seq_generator
    import seq_pkg::*;
#(
    parameter int unsigned MAX_LEN = SEQ_MAX_LEN,
    parameter int unsigned LEN_W   = SEQ_LEN_W,
    parameter int unsigned REP_W   = SEQ_REP_W,
    parameter int unsigned GAP     = SEQ_GAP
) (
    input  logic           clk,
    input  logic           rst,
    seq_generator_if.slave bus
);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    seq_state_e       state_q;
    logic [REP_W-1:0] rep_q;
    logic [GAP_W-1:0] gap_q;
    logic             seq_out_q;
    logic             seq_valid_q;
    logic             frame_start_q;
    logic             done_q;
    logic             err_q;
    logic             busy_q;

    logic load_ready;
    logic accept;
    logic len_ok;
    logic send_now;
    logic piso_bit;
    logic piso_first;
    logic piso_last;

    // The last bit is still on the wire while the FSM is already back in IDLE,
    // so readiness also waits for the output stage to drain.
    assign load_ready = (state_q == ST_IDLE) && !busy_q;
    assign accept     = bus.load_valid && load_ready;
    assign len_ok     = len_valid(32'(bus.len_in), MAX_LEN);
    assign send_now   = (state_q == ST_SEND) && !bus.abort;

    seq_piso #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .step_i  (send_now),
        .pat_i   (bus.pat_in),
        .len_i   (bus.len_in),
        .bit_o   (piso_bit),
        .first_o (piso_first),
        .last_o  (piso_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rep_q         <= '0;
            gap_q         <= '0;
            seq_out_q     <= 1'b0;
            seq_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            seq_out_q     <= send_now & piso_bit;
            seq_valid_q   <= send_now;
            frame_start_q <= send_now & piso_first;
            done_q        <= send_now & piso_last & (rep_q == '0);
            err_q         <= accept & !len_ok;
            busy_q        <= (state_q != ST_IDLE) && !bus.abort;

            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rep_q <= bus.rep_in;
                        if (len_ok) begin
                            state_q <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                    end else if (piso_last) begin
                        if (rep_q != '0) begin
                            rep_q <= rep_q - REP_W'(1);
                            if (GAP > 0) begin
                                state_q <= ST_GAP;
                                gap_q   <= '0;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                    end else if (gap_q == GAP_W'(GAP - 1)) begin
                        state_q <= ST_SEND;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.load_ready  = load_ready;
    assign bus.seq_out     = seq_out_q;
    assign bus.seq_valid   = seq_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: directed vector table, hand-written corner sequences,
// and random traffic, all cross-checked every cycle against a frame-list model.
module tb_seq_generator;
    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned REP_W   = 4;
    localparam int unsigned GAP     = 2;

    logic clk;
    logic rst;

    seq_generator_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

    seq_generator #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .REP_W   (REP_W),
        .GAP     (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_v(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: on an accepted load, the whole transfer is expanded into a
    // list of per-cycle observations that start one cycle after the accepting edge.
    typedef struct packed {
        logic so;
        logic sv;
        logic fs;
        logic dn;
        logic er;
        logic bz;
    } obs_t;

    obs_t mq[$];
    obs_t cur;
    logic mon_en;

    always @(posedge clk) begin
        logic               rdy;
        logic [MAX_LEN-1:0] p;
        int                 len;
        int                 rep;
        rdy = (mq.size() == 0) && !cur.bz;
        if (rst) begin
            mq.delete();
            cur = '0;
        end else if (rdy && bus.load_valid) begin
            cur = '0;
            p   = bus.pat_in;
            len = int'(bus.len_in);
            rep = int'(bus.rep_in);
            if (len >= 1 && len <= int'(MAX_LEN)) begin
                for (int f = 0; f <= rep; f++) begin
                    for (int i = len - 1; i >= 0; i--)
                        mq.push_back('{so: p[i], sv: 1'b1, fs: (i == len - 1),
                                       dn: (f == rep && i == 0), er: 1'b0, bz: 1'b1});
                    if (f < rep)
                        for (int g = 0; g < int'(GAP); g++)
                            mq.push_back('{so: 1'b0, sv: 1'b0, fs: 1'b0, dn: 1'b0, er: 1'b0, bz: 1'b1});
                end
            end else begin
                cur.er = 1'b1;
            end
        end else if (!rdy && bus.abort) begin
            mq.delete();
            cur = '0;
        end else if (mq.size() > 0) begin
            cur = mq.pop_front();
        end else begin
            cur = '0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_seq_out",     bus.seq_out,     cur.so);
            chk("mon_seq_valid",   bus.seq_valid,   cur.sv);
            chk("mon_frame_start", bus.frame_start, cur.fs);
            chk("mon_done",        bus.done,        cur.dn);
            chk("mon_err",         bus.err,         cur.er);
            chk("mon_busy",        bus.busy,        cur.bz);
            chk("mon_load_ready",  bus.load_ready,  (mq.size() == 0) && !cur.bz);
        end
    end

    typedef struct {
        logic [15:0] pat;
        logic [4:0]  len;
        logic [3:0]  rep;
        int          n;
        logic [31:0] exp_out;
        logic [31:0] exp_val;
        logic        exp_err;
        int          nfs;
    } vec_t;

    vec_t vecs[6];

    task automatic drive_load(input logic [15:0] pat, input logic [4:0] len, input logic [3:0] rep);
        bus.pat_in     = pat;
        bus.len_in     = len;
        bus.rep_in     = rep;
        bus.load_valid = 1'b1;
    endtask

    function automatic logic [7:0] outs_packed();
        return {2'b00, bus.seq_out, bus.seq_valid, bus.frame_start, bus.done, bus.err, bus.busy};
    endfunction

    initial begin
        int          fs_cnt;
        logic [15:0] pv;

        mon_en         = 1'b0;
        cur            = '0;
        rst            = 1'b1;
        bus.pat_in     = '0;
        bus.len_in     = '0;
        bus.rep_in     = '0;
        bus.load_valid = 1'b0;
        bus.abort      = 1'b0;

        vecs[0] = '{16'h0006, 5'd4,  4'd0, 4,  32'h0000_0006, 32'h0000_000F, 1'b0, 1};
        vecs[1] = '{16'h000B, 5'd4,  4'd1, 10, 32'h0000_02CB, 32'h0000_03CF, 1'b0, 2};
        vecs[2] = '{16'h1234, 5'd0,  4'd0, 0,  32'h0,         32'h0,         1'b1, 0};
        vecs[3] = '{16'h1234, 5'd17, 4'd2, 0,  32'h0,         32'h0,         1'b1, 0};
        vecs[4] = '{16'h0001, 5'd1,  4'd2, 7,  32'h0000_0049, 32'h0000_0049, 1'b0, 3};
        vecs[5] = '{16'hA5C3, 5'd16, 4'd0, 16, 32'h0000_A5C3, 32'h0000_FFFF, 1'b0, 1};

        repeat (3) @(negedge clk);
        chk_v("reset_outputs", outs_packed(), 8'h00);
        mon_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.load_ready, 1'b1);

        for (int v = 0; v < 6; v++) begin
            drive_load(vecs[v].pat, vecs[v].len, vecs[v].rep);
            @(negedge clk);
            bus.load_valid = 1'b0;
            chk("vec_err", bus.err, vecs[v].exp_err);
            chk("vec_ready_in_accept_cycle", bus.load_ready, vecs[v].exp_err);
            fs_cnt = 0;
            for (int c = 1; c <= vecs[v].n; c++) begin
                @(negedge clk);
                chk("vec_seq_out",   bus.seq_out,   vecs[v].exp_out[vecs[v].n - c]);
                chk("vec_seq_valid", bus.seq_valid, vecs[v].exp_val[vecs[v].n - c]);
                chk("vec_done",      bus.done,      c == vecs[v].n);
                fs_cnt += int'(bus.frame_start);
            end
            chk_v("vec_frame_starts", 8'(fs_cnt), 8'(vecs[v].nfs));
            @(negedge clk);
            chk("vec_ready_after", bus.load_ready, 1'b1);
            chk("vec_idle_valid", bus.seq_valid, 1'b0);
        end

        // Load attempt in mid-frame must not disturb the running pattern.
        pv = 16'h00B2;
        drive_load(pv, 5'd8, 4'd0);
        @(negedge clk);
        bus.load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("midload_seq_out", bus.seq_out, pv[8 - c]);
            chk("midload_done", bus.done, c == 8);
            if (c == 3) drive_load(16'h0F0F, 5'd4, 4'd1);
            if (c == 5) bus.load_valid = 1'b0;
        end
        @(negedge clk);
        chk("midload_ready_after", bus.load_ready, 1'b1);

        // Abort on the second bit, then a load together with a held abort.
        pv = 16'h00B5;
        drive_load(pv, 5'd8, 4'd3);
        @(negedge clk);
        bus.load_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_bit2", bus.seq_out, pv[6]);
        bus.abort = 1'b1;
        @(negedge clk);
        chk_v("abort_outputs_idle", outs_packed(), 8'h00);
        chk("abort_ready", bus.load_ready, 1'b1);
        pv = 16'h0006;
        drive_load(pv, 5'd4, 4'd0);
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.abort      = 1'b0;
        chk("abort_load_wins", bus.load_ready, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("after_abort_seq_out", bus.seq_out, pv[4 - c]);
            chk("after_abort_done", bus.done, c == 4);
        end
        @(negedge clk);

        // Reset mid-frame while sending 0,0,1,1,0, then a clean restart.
        pv = 16'h0006;
        drive_load(pv, 5'd5, 4'd0);
        @(negedge clk);
        bus.load_valid = 1'b0;
        for (int c = 1; c <= 3; c++) @(negedge clk);
        chk("rst_bit3", bus.seq_out, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk_v("rst_outputs_zero", outs_packed(), 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.load_ready, 1'b1);
        drive_load(pv, 5'd5, 4'd0);
        @(negedge clk);
        bus.load_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("restart_seq_out", bus.seq_out, pv[5 - c]);
            chk("restart_done", bus.done, c == 5);
        end
        @(negedge clk);

        // Random traffic; the per-cycle model check does the comparing.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst            = ($urandom_range(0, 499) == 0);
            bus.load_valid = ($urandom_range(0, 3) == 0);
            bus.abort      = ($urandom_range(0, 59) == 0);
            bus.pat_in     = 16'($urandom);
            bus.len_in     = 5'($urandom_range(0, 18));
            bus.rep_in     = 4'($urandom_range(0, 4));
            @(negedge clk);
        end
        rst            = 1'b0;
        bus.load_valid = 1'b0;
        bus.abort      = 1'b0;
        repeat (120) @(negedge clk);
        chk("final_ready", bus.load_ready, 1'b1);
        chk("final_busy", bus.busy, 1'b0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
